alu_result_stage: RTL

Registered consumer of the 16-bit ALU result interface (Out, Ofl, Z) in the execute stage. It captures each ALU result beat with a valid/ready handshake into a 2-entry skid buffer, evaluates the branch condition against the captured result, and presents write-back data, destination register and branch decision to the write-back/PC logic. It decouples the combinational ALU path from write-back stalls without dropping or duplicating results.

---
 rtl/alu_result_stage.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered consumer of the 16-bit ALU result interface.
// Captures ALU result beats through a valid/ready handshake into a 2-entry
// skid buffer (output slot + skid slot). It evaluates the branch condition on
// the incoming beat and presents write-back data, destination and branch
// decision downstream in strict FIFO order.
//
// Optional feature: define ALU_RES_STICKY_OFL_EN to enable the sticky overflow
// flag (ofl_sticky / ofl_clr). When it is undefined, ofl_sticky is tied low.
module alu_result_stage (
   input  logic        clk,
   input  logic        rst_n,
   // ALU side
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] alu_out,
   input  logic        alu_ofl,
   input  logic        alu_z,
   input  logic [2:0]  in_dst,
   input  logic        in_wr,
   input  logic        in_br,
   input  logic [1:0]  in_cond,
   // Write-back / PC side
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] wb_data,
   output logic [2:0]  wb_dst,
   output logic        wb_en,
   output logic        wb_ofl,
   output logic        br_taken,
   output logic        ofl_sticky,
   input  logic        ofl_clr
);

   typedef enum logic [1:0] {
      StEmpty,
      StOne,
      StFull
   } state_e;

   typedef struct packed {
      logic [15:0] data;
      logic [2:0]  dst;
      logic        wr;
      logic        ofl;
      logic        br;
   } beat_t;

   state_e state_q, state_d;
   beat_t  out_q, out_d;
   beat_t  skid_q, skid_d;
   beat_t  beat_in;
   logic   in_ready_q;
   logic   cond_true;
   logic   xfer_in;
   logic   xfer_out;

   assign out_valid = (state_q != StEmpty);
   assign in_ready  = in_ready_q;
   assign xfer_in   = in_valid && in_ready_q;
   assign xfer_out  = out_valid && out_ready;

   // Branch condition from the live ALU flags, resolved before capture.
   always_comb begin
      cond_true = 1'b0;
      unique case (in_cond)
         2'b00: cond_true = alu_z;
         2'b01: cond_true = !alu_z;
         2'b10: cond_true = alu_out[15];
         2'b11: cond_true = !alu_out[15];
         default: cond_true = 1'b0;
      endcase
   end

   // Assemble the incoming beat as it will be stored.
   always_comb begin
      beat_in      = '0;
      beat_in.data = alu_out;
      beat_in.dst  = in_dst;
      beat_in.wr   = in_wr;
      beat_in.ofl  = alu_ofl;
      beat_in.br   = in_br && cond_true;
   end

   // Occupancy FSM and slot next-state.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      unique case (state_q)
         StEmpty: begin
            if (xfer_in) begin
               out_d   = beat_in;
               state_d = StOne;
            end
         end
         StOne: begin
            if (xfer_in && xfer_out) begin
               // Output slot drains and refills in the same cycle.
               out_d = beat_in;
            end else if (xfer_in) begin
               skid_d  = beat_in;
               state_d = StFull;
            end else if (xfer_out) begin
               state_d = StEmpty;
            end
         end
         StFull: begin
            // in_ready is low here, so only the drain path can fire.
            if (xfer_out) begin
               out_d   = skid_q;
               state_d = StOne;
            end
         end
         default: state_d = StEmpty;
      endcase
   end

   // State, slots and registered ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StEmpty;
         out_q      <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         out_q      <= out_d;
         skid_q     <= skid_d;
         in_ready_q <= (state_d != StFull);
      end
   end

   assign wb_data  = out_q.data;
   assign wb_dst   = out_q.dst;
   assign wb_en    = out_q.wr;
   assign wb_ofl   = out_q.ofl;
   assign br_taken = out_q.br;

`ifdef ALU_RES_STICKY_OFL_EN
   logic sticky_q, sticky_d;

   // Set wins over clear so an overflow in the clearing cycle is not lost.
   always_comb begin
      sticky_d = sticky_q;
      if (ofl_clr) begin
         sticky_d = 1'b0;
      end
      if (xfer_in && alu_ofl) begin
         sticky_d = 1'b1;
      end
   end

   // Sticky overflow register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign ofl_sticky = sticky_q;
`else
   logic unused_ofl_clr;

   assign unused_ofl_clr = ofl_clr;
   assign ofl_sticky     = 1'b0;
`endif

endmodule
